// File: rtl/vec_ifid_pipe.sv
// ---------------------------------------------------------------------------
// vec_ifid_pipe
// Fetch + IF/ID stage for the vector ASIP. This block generates the PC and
// issues reads to a 1-cycle-latency instruction memory. It keeps the fetched
// word in an IF/ID register that tolerates stalls. A 1-entry skid buffer
// catches the word that is still in flight when Decode stalls. The block
// also handles redirect/flush and stops fetching when it loads a HALT opcode.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_i          synchronous reset, active-high
//   imem_addr_o    instruction memory word address (the PC register)
//   imem_rd_o      read strobe; imem_data_i is valid exactly one cycle later
//   imem_data_i    instruction memory read data
//   stall_i        Decode cannot accept; IF/ID holds
//   redirect_i     flush and restart fetch at redirect_pc_i (top priority)
//   redirect_pc_i  restart PC
//   instr_out_o    instruction presented to Decode
//   instr_pc_o     PC of instr_out_o
//   instr_valid_o  instr_out_o is a real instruction (0 = bubble)
//   halted_o       fetch stopped by a HALT opcode
//   retired_cnt_o  instructions accepted by Decode (wraps)
//
// FSM states
//   state   | meaning
//   ST_RUN  | fetching normally
//   ST_HALT | HALT word loaded, no fetch until a redirect
// ---------------------------------------------------------------------------
module vec_ifid_pipe #(
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       OPC_W    = 4,
  parameter logic [OPC_W-1:0]  HALT_OPC = 4'hF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic               imem_rd_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [INSTR_W-1:0] instr_out_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   retired_cnt_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 inflight_q, inflight_d;
  logic [ADDR_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0]   skid_q, skid_d;
  logic [ADDR_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 halted_q, halted_d;
  logic [CNT_W-1:0]     retired_q, retired_d;

  logic                 ld;
  logic                 load_real;
  logic [INSTR_W-1:0]   load_word;
  logic                 halt_load;
  logic                 issue;

  // Load/issue decisions. The skid entry is always older than anything in
  // flight, so it is the preferred load source.
  always_comb begin
    ld        = ~stall_i | ~instr_valid_q;
    load_word = skid_valid_q ? skid_q : imem_data_i;
    load_real = ld & (skid_valid_q | inflight_q);
    halt_load = (state_q == ST_RUN) & load_real &
                (load_word[INSTR_W-1 -: OPC_W] == HALT_OPC);
    // Issue only when the skid is empty. This keeps at most one word
    // between memory and IF/ID, so the single skid entry can never overflow.
    issue     = (state_q == ST_RUN) & ~rst_i & ~stall_i & ~skid_valid_q &
                ~redirect_i & ~halt_load;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    retired_d     = retired_q;

    if (issue) begin
      pc_d          = pc_q + ADDR_ONE;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (ld) begin
      if (skid_valid_q) begin
        instr_d       = skid_q;
        instr_pc_d    = skid_pc_q;
        instr_valid_d = 1'b1;
        // The issue rule makes this unreachable. It is still handled so
        // that a word is never silently dropped.
        skid_valid_d  = inflight_q;
        if (inflight_q) begin
          skid_d    = imem_data_i;
          skid_pc_d = inflight_pc_q;
        end
      end else if (inflight_q) begin
        instr_d       = imem_data_i;
        instr_pc_d    = inflight_pc_q;
        instr_valid_d = 1'b1;
      end else begin
        instr_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_d       = imem_data_i;
      skid_pc_d    = inflight_pc_q;
      skid_valid_d = 1'b1;
    end

    if (instr_valid_q & ~stall_i) begin
      retired_d = retired_q + CNT_ONE;
    end

    // The halt word itself is presented. Anything fetched behind it is dropped.
    if (halt_load) begin
      state_d      = ST_HALT;
      halted_d     = 1'b1;
      inflight_d   = 1'b0;
      skid_valid_d = 1'b0;
    end

    // A redirect flushes everything and leaves the IF/ID payload untouched
    // (only the valid bit drops). The flushed cycle does not retire.
    if (redirect_i) begin
      state_d       = ST_RUN;
      pc_d          = redirect_pc_i;
      inflight_d    = 1'b0;
      skid_valid_d  = 1'b0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      halted_d      = 1'b0;
      retired_d     = retired_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_pc_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      retired_q     <= retired_d;
    end
  end

  // A skid load that coincides with an in-flight word would mean the issue
  // rule was broken.
  a_no_skid_collision : assert property (
    @(posedge clk_i) disable iff (rst_i)
      !(ld && skid_valid_q && inflight_q && !redirect_i)
  );

  assign imem_addr_o   = pc_q;
  assign imem_rd_o     = issue;
  assign instr_out_o   = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign halted_o      = halted_q;
  assign retired_cnt_o = retired_q;

endmodule
